// File: rtl/param_counter.sv
// -----------------------------------------------------------------------------
// param_counter
//   Up/down modulo counter with optional saturation and an enable prescaler.
//   A count step happens once every PRESCALE enabled cycles. The count runs
//   between 0 and MOD_MAX. At a limit it either wraps to the other end, with a
//   one-cycle wrap pulse, or holds (SATURATE=1).
//
// Parameters
//   WIDTH    : counter width in bits (1..32)
//   MOD_MAX  : terminal count value (1..2**WIDTH-1)
//   SATURATE : 0 = wrap at the limits, 1 = hold at the limits
//   PRESCALE : enabled cycles per count step (1..65535)
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   en       : count enable; gates the prescaler
//   clr      : synchronous clear (highest priority after reset)
//   load     : synchronous load of min(load_val, MOD_MAX)
//   load_val : value to load
//   up_dn    : direction, 1 = up, 0 = down
//   q        : registered count
//   tc       : terminal count flag, combinational from q and up_dn
//   wrap     : registered one-cycle pulse, high while q shows a wrapped value
// -----------------------------------------------------------------------------
module param_counter #(
  parameter int          WIDTH    = 8,
  parameter int unsigned MOD_MAX  = (2**WIDTH) - 1,
  parameter int          SATURATE = 0,
  parameter int          PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // The prescaler needs at least one bit even when PRESCALE=1. In that case
  // it stays at 0, which equals PS_LAST, so every enabled cycle is a step.
  localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = MOD_MAX[WIDTH-1:0];

  logic [WIDTH-1:0] q_reg, q_next;
  logic [PS_W-1:0]  ps_reg, ps_next;
  logic             wrap_reg, wrap_next;

  always_comb begin
    q_next    = q_reg;
    ps_next   = ps_reg;
    wrap_next = 1'b0;

    if (clr) begin
      q_next  = '0;
      ps_next = '0;
    end else if (load) begin
      q_next  = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      ps_next = '0;
    end else if (en) begin
      if (ps_reg == PS_LAST) begin
        // Step cycle. up_dn is only examined here, so direction changes
        // between steps leave the prescaler alone.
        ps_next = '0;
        if (up_dn) begin
          if (q_reg == MAX_VAL) begin
            if (SATURATE == 0) begin
              q_next    = '0;
              wrap_next = 1'b1;
            end
          end else begin
            q_next = q_reg + WIDTH'(1);
          end
        end else begin
          if (q_reg == '0) begin
            if (SATURATE == 0) begin
              q_next    = MAX_VAL;
              wrap_next = 1'b1;
            end
          end else begin
            q_next = q_reg - WIDTH'(1);
          end
        end
      end else begin
        ps_next = ps_reg + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg    <= '0;
      ps_reg   <= '0;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      ps_reg   <= ps_next;
      wrap_reg <= wrap_next;
    end
  end

  assign q    = q_reg;
  assign wrap = wrap_reg;
  assign tc   = up_dn ? (q_reg == MAX_VAL) : (q_reg == '0);

endmodule

// File: tb/tb_param_counter.sv
// -----------------------------------------------------------------------------
// tb_param_counter
//   Three counters (WIDTH=4, MOD_MAX=9) share one set of inputs:
//     [0] PRESCALE=1 SATURATE=0, [1] PRESCALE=1 SATURATE=1,
//     [2] PRESCALE=3 SATURATE=0.
//   Every cycle all three are compared with an integer reference model. On
//   top of that, a vector table and hand-written sequences carry fixed
//   expected values.
// -----------------------------------------------------------------------------
module tb_param_counter;

  localparam int MAXV = 9;
  localparam int PS  [3] = '{1, 1, 3};
  localparam int SAT [3] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       rst_n, en, clr, load, up_dn;
  logic [3:0] load_val;
  logic [3:0] q_o    [3];
  logic       tc_o   [3];
  logic       wrap_o [3];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model: integer count and a count of enabled cycles since the
  // last step.
  int m_q [3];
  int m_c [3];
  int m_w [3];

  always #5 clk = ~clk;

  param_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(0), .PRESCALE(1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .up_dn(up_dn), .q(q_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]));

  param_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1), .PRESCALE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .up_dn(up_dn), .q(q_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]));

  param_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(0), .PRESCALE(3)) dut_ps3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .up_dn(up_dn), .q(q_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2]));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int nq;
      if (!rst_n || clr) begin
        m_q[k] = 0; m_c[k] = 0; m_w[k] = 0;
      end else if (load) begin
        m_q[k] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
        m_c[k] = 0; m_w[k] = 0;
      end else if (en) begin
        m_w[k] = 0;
        m_c[k] = m_c[k] + 1;
        if (m_c[k] == PS[k]) begin
          m_c[k] = 0;
          nq = up_dn ? m_q[k] + 1 : m_q[k] - 1;
          if (nq > MAXV) begin
            nq = (SAT[k] != 0) ? MAXV : 0;
            m_w[k] = (SAT[k] != 0) ? 0 : 1;
          end else if (nq < 0) begin
            nq = (SAT[k] != 0) ? 0 : MAXV;
            m_w[k] = (SAT[k] != 0) ? 0 : 1;
          end
          m_q[k] = nq;
        end
      end else begin
        m_w[k] = 0;
      end
    end
  endtask

  // One clock: the model takes the inputs present at the edge, then all
  // DUT outputs are compared 1 time unit later while the inputs are still
  // held.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    $display("cyc %0d rst_n=%0b en=%0b clr=%0b load=%0b lv=%0d up=%0b | q=%0d/%0d/%0d wrap=%0b/%0b/%0b tc=%0b/%0b/%0b",
             cyc, rst_n, en, clr, load, load_val, up_dn,
             q_o[0], q_o[1], q_o[2], wrap_o[0], wrap_o[1], wrap_o[2],
             tc_o[0], tc_o[1], tc_o[2]);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_q[%0d]", k), int'(q_o[k]), m_q[k]);
      chk($sformatf("model_wrap[%0d]", k), int'(wrap_o[k]), m_w[k]);
      chk($sformatf("model_tc[%0d]", k), int'(tc_o[k]),
          (up_dn ? (m_q[k] == MAXV) : (m_q[k] == 0)) ? 1 : 0);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic c, input logic l,
                       input logic [3:0] lv, input logic u);
    rst_n = r; en = e; clr = c; load = l; load_val = lv; up_dn = u;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    tick();
  endtask

  typedef struct {
    logic       r, e, c, l;
    logic [3:0] lv;
    logic       u;
    int         eq, ew, etc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic c, input logic l,
                              input logic [3:0] lv, input logic u,
                              input int eq, input int ew, input int etc);
    vec_t v;
    v.r = r; v.e = e; v.c = c; v.l = l; v.lv = lv; v.u = u;
    v.eq = eq; v.ew = ew; v.etc = etc;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // Vector table for the wrapping PRESCALE=1 counter.
    for (int i = 1; i <= 9; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 1, i, 0, (i == 9) ? 1 : 0));
    tbl.push_back(mk(1, 1, 0, 0, 0,  1, 0, 1, 0));  // 9 -> 0 wraps
    tbl.push_back(mk(1, 1, 0, 0, 0,  1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 1));  // down to 0, tc while down
    tbl.push_back(mk(1, 1, 0, 0, 0,  0, 9, 1, 0));  // 0 -> 9 wraps
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 9, 0, 0));  // hold
    tbl.push_back(mk(1, 0, 0, 1, 12, 1, 9, 0, 1));  // load clamps to MOD_MAX
    tbl.push_back(mk(1, 1, 1, 1, 12, 1, 0, 0, 0));  // clr beats load
    tbl.push_back(mk(1, 1, 0, 1, 5,  1, 5, 0, 0));  // load beats step
    tbl.push_back(mk(1, 1, 0, 0, 0,  1, 6, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 0, 0, 0));  // clr

    do_reset();
    chk("reset_q", int'(q_o[0]), 0);
    chk("reset_wrap", int'(wrap_o[0]), 0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].l, tbl[i].lv, tbl[i].u);
      tick();
      chk($sformatf("vec%0d_q", i), int'(q_o[0]), tbl[i].eq);
      chk($sformatf("vec%0d_wrap", i), int'(wrap_o[0]), tbl[i].ew);
      chk($sformatf("vec%0d_tc", i), int'(tc_o[0]), tbl[i].etc);
    end

    // Saturating counter: holds at 9 without wrap, then counts down.
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      drive(1, 1, 0, 0, 0, 1);
      tick();
      chk("sat_up_q", int'(q_o[1]), (i > 9) ? 9 : i);
      chk("sat_up_wrap", int'(wrap_o[1]), 0);
    end
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      tick();
      chk("sat_dn_q", int'(q_o[1]), 9 - i);
    end

    // PRESCALE=3: nine enabled cycles give q=3; a 2-cycle en gap delays the step.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      drive(1, 1, 0, 0, 0, 1);
      tick();
      chk("ps3_q", int'(q_o[2]), i / 3);
    end
    drive(1, 1, 0, 0, 0, 1); tick(); chk("ps3_gap_a", int'(q_o[2]), 3);
    drive(1, 0, 0, 0, 0, 1); tick(); chk("ps3_gap_b", int'(q_o[2]), 3);
    drive(1, 0, 0, 0, 0, 0); tick(); chk("ps3_gap_c", int'(q_o[2]), 3);  // up_dn toggles while idle
    drive(1, 1, 0, 0, 0, 1); tick(); chk("ps3_gap_d", int'(q_o[2]), 3);
    drive(1, 1, 0, 0, 0, 1); tick(); chk("ps3_gap_e", int'(q_o[2]), 4);

    // Reset at q=5 with prescaler=1, then a full interval before the next step.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 0, 1);
      tick();
    end
    chk("ps3_pre_rst_q", int'(q_o[2]), 5);
    drive(0, 1, 0, 0, 0, 1); tick(); chk("ps3_rst_q", int'(q_o[2]), 0);
    drive(1, 1, 0, 0, 0, 1); tick(); chk("ps3_after_rst1", int'(q_o[2]), 0);
    drive(1, 1, 0, 0, 0, 1); tick(); chk("ps3_after_rst2", int'(q_o[2]), 0);
    drive(1, 1, 0, 0, 0, 1); tick(); chk("ps3_after_rst3", int'(q_o[2]), 1);

    // Random stimulus checked against the model inside tick().
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 14) == 0),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 4) != 0) ^ (i >= 200));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
- REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits, legal range 1..32.
- REQ-002 SHALL have parameter MOD_MAX, default 2**WIDTH-1: terminal count value, legal range 1..2**WIDTH-1.
- REQ-003 SHALL have parameter SATURATE, default 0: 0 selects wrap at the limits, 1 selects hold at the limits.
- REQ-004 SHALL have parameter PRESCALE, default 1: number of enabled cycles per count step, legal range 1..65535.
- REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
- REQ-007 SHALL have port en, input, 1 bit: count enable.
- REQ-008 SHALL have port clr, input, 1 bit: synchronous clear.
- REQ-009 SHALL have port load, input, 1 bit: synchronous load strobe.
- REQ-010 SHALL have port load_val, input, WIDTH bits: value to load.
- REQ-011 SHALL have port up_dn, input, 1 bit: direction, 1 = up, 0 = down.
- REQ-012 SHALL have port q, output, WIDTH bits: registered count.
- REQ-013 SHALL have port tc, output, 1 bit: terminal-count flag, combinational from q and up_dn.
- REQ-014 SHALL have port wrap, output, 1 bit: registered one-cycle pulse marking a wrap event.

Function
- REQ-015 SHALL apply this priority per rising clk edge: rst_n low, then clr, then load, then count step, then hold.
- REQ-016 SHALL, on clr=1, set q to 0, clear the prescaler and drive wrap=0, regardless of load and en.
- REQ-017 SHALL, on load=1 with clr=0, set q to min(load_val, MOD_MAX), clear the prescaler and drive wrap=0.
- REQ-018 SHALL keep an internal prescaler of width ceil(log2(PRESCALE)), minimum 1 bit, that advances only on cycles with en=1, clr=0 and load=0.
- REQ-019 SHALL generate a step when en=1 and the prescaler equals PRESCALE-1; on that cycle the prescaler returns to 0.
- REQ-020 SHALL, with PRESCALE=1, step on every cycle with en=1.
- REQ-021 SHALL, with en=0, hold both q and the prescaler.
- REQ-022 SHALL sample up_dn only on step cycles; changing up_dn between steps SHALL NOT disturb the prescaler.
- REQ-023 SHALL, on an up step with q<MOD_MAX, set q to q+1.
- REQ-024 SHALL, on an up step with q=MOD_MAX, set q to 0 with wrap=1 when SATURATE=0, or hold q with wrap=0 when SATURATE=1.
- REQ-025 SHALL, on a down step with q>0, set q to q-1.
- REQ-026 SHALL, on a down step with q=0, set q to MOD_MAX with wrap=1 when SATURATE=0, or hold q with wrap=0 when SATURATE=1.
- REQ-027 SHALL assert wrap for exactly one cycle, coincident with q showing the wrapped value, and drive it 0 on all other cycles.
- REQ-028 SHALL drive tc=1 exactly when (up_dn=1 and q=MOD_MAX) or (up_dn=0 and q=0).
- REQ-029 SHALL keep all arithmetic WIDTH bits wide and unsigned; q SHALL never exceed MOD_MAX.

Reset
- REQ-030 SHALL, on a clk edge with rst_n=0, set q=0, prescaler=0 and wrap=0, overriding all other inputs.
- REQ-031 SHALL treat reset asserted mid-prescale or mid-count identically to reset from idle; counting restarts with a full PRESCALE interval after rst_n returns high.

Verification (WIDTH=4, MOD_MAX=9, PRESCALE=1, SATURATE=0 unless stated)
- REQ-032 SHALL cover: en=1, up_dn=1 for 11 cycles from reset -> q=1..9, then 0 with wrap=1 for one cycle; tc=1 while q=9.
- REQ-033 SHALL cover: SATURATE=1, up count past 9 -> q holds 9, wrap stays 0; then up_dn=0 -> q=8,7,...
- REQ-034 SHALL cover: down count from q=0 -> q=9 with wrap=1; tc=1 while q=0 and up_dn=0.
- REQ-035 SHALL cover: load=1, load_val=12 -> q=9; load=1 and clr=1 together -> q=0; load=1 with en=1 -> the loaded value wins, no step that cycle.
- REQ-036 SHALL cover: PRESCALE=3, en=1 for 9 cycles -> q=3; en low for 2 cycles mid-interval -> step delayed by 2 cycles.
- REQ-037 SHALL cover: rst_n=0 for one edge at q=5 with prescaler=1 (PRESCALE=3) -> q=0, and the next step occurs 3 enabled cycles after rst_n returns high.
